// File: rtl/packet_receiver.sv
// rtl/packet_receiver.sv - link-side packet receiver writing one input-buffer slot per intact packet
module packet_receiver #(
    parameter int UWIDTH    = 8,
    parameter int PTR_IN_SZ = 4,
    parameter int SIZE_BITS = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 packet_valid,
    input  logic [UWIDTH-1:0]    packet_in,
    input  logic                 wfull,
    output logic                 wen,
    output logic [PTR_IN_SZ-1:0] waddr,
    output logic [UWIDTH-1:0]    wdata,
    output logic                 winc,
    output logic                 crc_err,
    output logic                 abort_err,
    output logic                 drop,
    output logic                 busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DST,
        ST_SIZE,
        ST_DATA,
        ST_CRC,
        ST_DROP
    } state_t;

    state_t               state, state_n;
    logic [UWIDTH-1:0]    crc, crc_n;
    logic [SIZE_BITS-1:0] cnt, cnt_n;
    logic                 wen_n, winc_n, crc_err_n, abort_n, drop_n;
    logic [PTR_IN_SZ-1:0] waddr_n;
    logic [UWIDTH-1:0]    wdata_n;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            crc       <= '0;
            cnt       <= '0;
            wen       <= 1'b0;
            waddr     <= '0;
            wdata     <= '0;
            winc      <= 1'b0;
            crc_err   <= 1'b0;
            abort_err <= 1'b0;
            drop      <= 1'b0;
        end else begin
            state     <= state_n;
            crc       <= crc_n;
            cnt       <= cnt_n;
            wen       <= wen_n;
            waddr     <= waddr_n;
            wdata     <= wdata_n;
            winc      <= winc_n;
            crc_err   <= crc_err_n;
            abort_err <= abort_n;
            drop      <= drop_n;
        end
    end

    always_comb begin
        state_n   = state;
        crc_n     = crc;
        cnt_n     = cnt;
        wen_n     = 1'b0;
        waddr_n   = waddr;
        wdata_n   = wdata;
        winc_n    = 1'b0;
        crc_err_n = 1'b0;
        abort_n   = 1'b0;
        drop_n    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (packet_valid) begin
                    if (wfull) begin
                        drop_n  = 1'b1;
                        state_n = ST_DROP;
                    end else begin
                        wen_n   = 1'b1;
                        waddr_n = '0;
                        wdata_n = packet_in;
                        crc_n   = packet_in;
                        state_n = ST_DST;
                    end
                end
            end
            ST_DST: begin
                if (!packet_valid) begin
                    abort_n = 1'b1;
                    state_n = ST_IDLE;
                end else begin
                    wen_n   = 1'b1;
                    waddr_n = PTR_IN_SZ'(1);
                    wdata_n = packet_in;
                    crc_n   = crc ^ packet_in;
                    state_n = ST_SIZE;
                end
            end
            ST_SIZE: begin
                if (!packet_valid) begin
                    abort_n = 1'b1;
                    state_n = ST_IDLE;
                end else begin
                    wen_n   = 1'b1;
                    waddr_n = PTR_IN_SZ'(2);
                    wdata_n = packet_in;
                    crc_n   = crc ^ packet_in;
                    // Upper SIZE bits are stored but do not contribute to length
                    cnt_n   = packet_in[SIZE_BITS-1:0];
                    state_n = (packet_in[SIZE_BITS-1:0] != '0) ? ST_DATA : ST_CRC;
                end
            end
            ST_DATA: begin
                if (!packet_valid) begin
                    abort_n = 1'b1;
                    state_n = ST_IDLE;
                end else begin
                    wen_n   = 1'b1;
                    waddr_n = waddr + PTR_IN_SZ'(1);
                    wdata_n = packet_in;
                    crc_n   = crc ^ packet_in;
                    cnt_n   = cnt - SIZE_BITS'(1);
                    if (cnt == SIZE_BITS'(1))
                        state_n = ST_CRC;
                end
            end
            ST_CRC: begin
                if (!packet_valid) begin
                    abort_n = 1'b1;
                end else if (packet_in == crc) begin
                    winc_n = 1'b1;
                end else begin
                    crc_err_n = 1'b1;
                end
                state_n = ST_IDLE;
            end
            ST_DROP: begin
                if (!packet_valid)
                    state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign busy = (state != ST_IDLE);

endmodule
